// File: rtl/lcd_status_reader_if.sv
// Bus bundle for the HD44780 status reader: request handshake, LCD pins and results.
interface lcd_status_reader_if;
  logic       start;
  logic       wait_ready;
  logic [7:0] lcd_db_in;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic       active;
  logic       done;
  logic       ready;
  logic [6:0] addr;
  logic       timeout;

  // Requester side: issues reads and drives the pad read-back value.
  modport master (
    output start, wait_ready, lcd_db_in,
    input  lcd_rs, lcd_rw, lcd_e, active, done, ready, addr, timeout
  );

  // Reader side: owns the LCD strobes and reports busy flag / address counter.
  modport slave (
    input  start, wait_ready, lcd_db_in,
    output lcd_rs, lcd_rw, lcd_e, active, done, ready, addr, timeout
  );
endinterface

// File: rtl/lcd_status_reader.sv
// HD44780 status read engine: fetches busy flag and address counter with
// RS=0/RW=1 read cycles, either once or polling until the LCD is not busy.
module lcd_status_reader #(
  parameter int SETUP_CYC = 2,
  parameter int EHIGH_CYC = 12,
  parameter int EHOLD_CYC = 2,
  parameter int GAP_CYC   = 25,
  parameter int MAX_READS = 200
) (
  input logic              clk,
  input logic              rst,
  lcd_status_reader_if.slave bus
);

  localparam int MAX_AB  = (SETUP_CYC > EHIGH_CYC) ? SETUP_CYC : EHIGH_CYC;
  localparam int MAX_CD  = (EHOLD_CYC > GAP_CYC) ? EHOLD_CYC : GAP_CYC;
  localparam int MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_ALL = (MAX_ABC > MAX_READS) ? MAX_ABC : MAX_READS;
  localparam int CW_RAW  = $clog2(MAX_ALL) + 1;
  localparam int CW      = (CW_RAW < 5) ? 5 : CW_RAW;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_EHIGH = 3'd2;
  localparam logic [2:0] ST_EHOLD = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          phase_last;
  logic          sample_now;
  logic          gap_end;
  logic          retry;
  logic          mode;
  logic          busy_s;
  logic [7:0]    read_cnt;

  // Flags the final cycle of whichever timed phase the FSM is in.
  always_comb begin
    phase_last = 1'b0;
    case (state)
      ST_SETUP: phase_last = (cnt == CW'(SETUP_CYC - 1));
      ST_EHIGH: phase_last = (cnt == CW'(EHIGH_CYC - 1));
      ST_EHOLD: phase_last = (cnt == CW'(EHOLD_CYC - 1));
      ST_GAP:   phase_last = (cnt == CW'(GAP_CYC - 1));
      default:  phase_last = 1'b0;
    endcase
  end

  assign sample_now = (state == ST_EHIGH) && phase_last;
  assign gap_end    = (state == ST_GAP) && phase_last;
  assign retry      = mode && busy_s && (read_cnt < 8'(MAX_READS));

  // Next-state selection; a poll loops back to SETUP while busy and under the read limit.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_SETUP;
      ST_SETUP: if (phase_last) state_nxt = ST_EHIGH;
      ST_EHIGH: if (phase_last) state_nxt = ST_EHOLD;
      ST_EHOLD: if (phase_last) state_nxt = ST_GAP;
      ST_GAP:   if (phase_last) state_nxt = retry ? ST_SETUP : ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register and per-phase cycle counter, restarted on every phase change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == ST_IDLE || state == ST_DONE)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

  // Request latching, data capture on the last E-high cycle, and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode        <= 1'b0;
      busy_s      <= 1'b0;
      read_cnt    <= 8'd0;
      bus.addr    <= 7'd0;
      bus.ready   <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.start) begin
        mode        <= bus.wait_ready;
        bus.timeout <= 1'b0;
        read_cnt    <= 8'd0;
      end
      if (sample_now) begin
        bus.addr <= bus.lcd_db_in[6:0];
        busy_s   <= bus.lcd_db_in[7];
        if (read_cnt != 8'hFF)
          read_cnt <= read_cnt + 8'd1;
      end
      if (gap_end && !retry) begin
        bus.ready <= ~busy_s;
        if (mode && busy_s)
          bus.timeout <= 1'b1;
      end
    end
  end

  // Registered LCD strobes and status outputs, decoded from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.lcd_rs <= 1'b0;
      bus.lcd_rw <= 1'b0;
      bus.lcd_e  <= 1'b0;
      bus.active <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.lcd_rs <= 1'b0;
      bus.lcd_rw <= state_nxt inside {ST_SETUP, ST_EHIGH, ST_EHOLD, ST_GAP};
      bus.active <= state_nxt inside {ST_SETUP, ST_EHIGH, ST_EHOLD, ST_GAP};
      bus.lcd_e  <= (state_nxt == ST_EHIGH);
      bus.done   <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_lcd_status_reader.sv
// Directed bench for lcd_status_reader: default instance for single/poll/sampling/
// ignored-start/reset scenarios, plus a MAX_READS=4 instance for the poll timeout.
module tb_lcd_status_reader;

  logic clk;
  logic rst;

  lcd_status_reader_if bus_a ();
  lcd_status_reader_if bus_b ();

  lcd_status_reader u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  lcd_status_reader #(.MAX_READS(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int checks = 0;
  int errors = 0;

  int ncyc = 0;
  int e_rise_a = 0, e_fall_a = 0, e_cyc_a = 0, rw_cyc_a = 0, done_cnt_a = 0, done_at_a = 0;
  int e_rise_b = 0, done_cnt_b = 0;
  int fall_at_a = 0;
  bit fall_ok_a = 0;
  bit e_prev_a = 0, e_prev_b = 0;
  int gaps_a[$];

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor for instance A, sampled mid-cycle: strobe edges, widths, E-low gaps within one op.
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (bus_a.lcd_e && !e_prev_a) begin
      e_rise_a <= e_rise_a + 1;
      if (fall_ok_a) gaps_a.push_back(ncyc + 1 - fall_at_a);
    end
    if (!bus_a.lcd_e && e_prev_a) begin
      e_fall_a  <= e_fall_a + 1;
      fall_at_a <= ncyc + 1;
      fall_ok_a <= 1'b1;
    end
    if (!bus_a.active) fall_ok_a <= 1'b0;
    if (bus_a.lcd_e)  e_cyc_a  <= e_cyc_a + 1;
    if (bus_a.lcd_rw) rw_cyc_a <= rw_cyc_a + 1;
    if (bus_a.done) begin
      done_cnt_a <= done_cnt_a + 1;
      done_at_a  <= ncyc + 1;
    end
    e_prev_a <= bus_a.lcd_e;
  end

  // Monitor for instance B: E pulses and done pulses.
  always @(negedge clk) begin
    if (bus_b.lcd_e && !e_prev_b) e_rise_b <= e_rise_b + 1;
    if (bus_b.done) done_cnt_b <= done_cnt_b + 1;
    e_prev_b <= bus_b.lcd_e;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues a one-cycle start on the chosen instance; start_n is the negedge index of SETUP cycle 1.
  task automatic applyStimulus(input bit which, input bit wr, input logic [7:0] db, output int start_n);
    @(negedge clk);
    if (which) begin
      bus_b.lcd_db_in = db; bus_b.wait_ready = wr; bus_b.start = 1'b1;
    end else begin
      bus_a.lcd_db_in = db; bus_a.wait_ready = wr; bus_a.start = 1'b1;
    end
    @(negedge clk);
    #1;
    start_n = ncyc;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic waitDone(input bit which, input int base, input int limit, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if ((which ? done_cnt_b : done_cnt_a) > base) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic waitEHigh(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (bus_a.lcd_e) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int sn;
    int er0, ec0, rw0, dc0, ef0, gb, eb0, db0;
    bit fell;

    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.wait_ready = 1'b0; bus_a.lcd_db_in = 8'h00;
    bus_b.start = 1'b0; bus_b.wait_ready = 1'b0; bus_b.lcd_db_in = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_e",      {31'd0, bus_a.lcd_e},   32'd0);
    checkOutput("rst_rw",     {31'd0, bus_a.lcd_rw},  32'd0);
    checkOutput("rst_rs",     {31'd0, bus_a.lcd_rs},  32'd0);
    checkOutput("rst_active", {31'd0, bus_a.active},  32'd0);
    checkOutput("rst_done",   {31'd0, bus_a.done},    32'd0);
    checkOutput("rst_ready",  {31'd0, bus_a.ready},   32'd0);
    checkOutput("rst_addr",   {25'd0, bus_a.addr},    32'd0);
    checkOutput("rst_timeout",{31'd0, bus_a.timeout}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single read of 0x85: busy set, address 0x05.
    $display("[TB] single read");
    er0 = e_rise_a; ec0 = e_cyc_a; rw0 = rw_cyc_a; dc0 = done_cnt_a;
    applyStimulus(1'b0, 1'b0, 8'h85, sn);
    checkOutput("single_rs", {31'd0, bus_a.lcd_rs}, 32'd0);
    waitDone(1'b0, dc0, 100, "single_done_seen");
    checkOutput("single_latency", done_at_a - sn + 1, 32'd42);
    checkOutput("single_addr",    {25'd0, bus_a.addr},    32'h05);
    checkOutput("single_ready",   {31'd0, bus_a.ready},   32'd0);
    checkOutput("single_timeout", {31'd0, bus_a.timeout}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("single_e_pulses", e_rise_a - er0,  32'd1);
    checkOutput("single_e_width",  e_cyc_a - ec0,   32'd12);
    checkOutput("single_rw_cycles",rw_cyc_a - rw0,  32'd41);
    checkOutput("single_done_cnt", done_cnt_a - dc0,32'd1);

    // Poll: busy for three reads, then ready with address 0x10.
    $display("[TB] polling");
    er0 = e_rise_a; dc0 = done_cnt_a; ef0 = e_fall_a; gb = gaps_a.size();
    applyStimulus(1'b0, 1'b1, 8'h80, sn);
    bus_a.wait_ready = 1'b0;
    fell = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (e_fall_a - ef0 >= 3) begin
        fell = 1'b1;
        break;
      end
    end
    checkOutput("poll_third_fall_seen", {31'd0, fell}, 32'd1);
    bus_a.lcd_db_in = 8'h10;
    waitDone(1'b0, dc0, 200, "poll_done_seen");
    checkOutput("poll_addr",    {25'd0, bus_a.addr},    32'h10);
    checkOutput("poll_ready",   {31'd0, bus_a.ready},   32'd1);
    checkOutput("poll_timeout", {31'd0, bus_a.timeout}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("poll_e_pulses", e_rise_a - er0,   32'd4);
    checkOutput("poll_done_cnt", done_cnt_a - dc0, 32'd1);
    checkOutput("poll_gap_count", gaps_a.size() - gb, 32'd3);
    for (int i = gb; i < gaps_a.size(); i++)
      checkOutput($sformatf("poll_gap%0d", i - gb), gaps_a[i], 32'd29);

    // Data valid only on the last E-high cycle; 0xFF everywhere else.
    $display("[TB] sampling point");
    dc0 = done_cnt_a;
    applyStimulus(1'b0, 1'b0, 8'hFF, sn);
    waitEHigh("sample_e_seen");
    repeat (11) @(negedge clk);
    bus_a.lcd_db_in = 8'h2A;
    @(negedge clk);
    bus_a.lcd_db_in = 8'hFF;
    waitDone(1'b0, dc0, 100, "sample_done_seen");
    checkOutput("sample_addr",  {25'd0, bus_a.addr},  32'h2A);
    checkOutput("sample_ready", {31'd0, bus_a.ready}, 32'd1);

    // Starts during SETUP, GAP and DONE must all be dropped.
    $display("[TB] ignored starts");
    er0 = e_rise_a; dc0 = done_cnt_a;
    applyStimulus(1'b0, 1'b0, 8'h85, sn);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (18) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    waitDone(1'b0, dc0, 100, "ign_done_seen");
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    checkOutput("ign_latency",  done_at_a - sn + 1, 32'd42);
    checkOutput("ign_e_pulses", e_rise_a - er0,     32'd1);
    checkOutput("ign_done_cnt", done_cnt_a - dc0,   32'd1);
    checkOutput("ign_active",   {31'd0, bus_a.active}, 32'd0);

    // Poll timeout on the MAX_READS=4 instance with busy never clearing.
    $display("[TB] poll timeout");
    eb0 = e_rise_b; db0 = done_cnt_b;
    applyStimulus(1'b1, 1'b1, 8'h80, sn);
    waitDone(1'b1, db0, 400, "to_done_seen");
    checkOutput("to_timeout", {31'd0, bus_b.timeout}, 32'd1);
    checkOutput("to_ready",   {31'd0, bus_b.ready},   32'd0);
    checkOutput("to_addr",    {25'd0, bus_b.addr},    32'h00);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("to_e_pulses", e_rise_b - eb0,   32'd4);
    checkOutput("to_done_cnt", done_cnt_b - db0, 32'd1);
    checkOutput("to_timeout_held", {31'd0, bus_b.timeout}, 32'd1);
    db0 = done_cnt_b;
    applyStimulus(1'b1, 1'b0, 8'h03, sn);
    checkOutput("to_timeout_cleared", {31'd0, bus_b.timeout}, 32'd0);
    waitDone(1'b1, db0, 100, "to_single_done_seen");
    checkOutput("to_single_ready", {31'd0, bus_b.ready}, 32'd1);
    checkOutput("to_single_addr",  {25'd0, bus_b.addr},  32'h03);

    // Asynchronous reset in EHIGH cycle 5 drops the bus at once and no done follows.
    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 1'b0, 8'h85, sn);
    waitEHigh("mid_e_seen");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_e",      {31'd0, bus_a.lcd_e},  32'd0);
    checkOutput("mid_rw",     {31'd0, bus_a.lcd_rw}, 32'd0);
    checkOutput("mid_active", {31'd0, bus_a.active}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    er0 = e_rise_a; dc0 = done_cnt_a;
    repeat (60) @(negedge clk);
    #1;
    checkOutput("mid_no_done",   done_cnt_a - dc0, 32'd0);
    checkOutput("mid_no_e",      e_rise_a - er0,   32'd0);
    checkOutput("mid_idle",      {31'd0, bus_a.active}, 32'd0);
    checkOutput("mid_addr_reset",{25'd0, bus_a.addr},   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_status_reader.md
Name: lcd_status_reader

Overview:
Performs HD44780-style read cycles (RS=0, RW=1) to fetch the busy flag (DB7) and address counter (DB6..DB0). This is the read-direction counterpart to the existing write-only LCD driver path. It sits beside lcd_driver on the same lcd_rs/lcd_rw/lcd_e bus, and the top level muxes ownership using the active output. It supports a single status read or polling until the LCD is not busy, with a bounded retry count.

Parameters:
SETUP_CYC, 2, clk cycles with RS/RW stable before E rises (tAS)
EHIGH_CYC, 12, clk cycles E held high; data sampled on the last of these
EHOLD_CYC, 2, clk cycles after E falls with RS/RW held (tAH)
GAP_CYC, 25, clk cycles of E low before the next read or completion (min E cycle time)
MAX_READS, 200, max read cycles per poll request before timeout (1..255)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request pulse; ignored while active=1
wait_ready  input  1  sampled with start: 1=poll until DB7=0, 0=single read
lcd_db_in  input  8  LCD data bus as read back from the pad
lcd_rs  output  1  register select, 0 throughout any read
lcd_rw  output  1  1 from SETUP entry through end of GAP
lcd_e  output  1  enable strobe
active  output  1  block owns LCD bus (SETUP..GAP inclusive)
done  output  1  one-cycle pulse at completion
ready  output  1  last sampled DB7==0, valid from done until next start
addr  output  7  last sampled DB6..DB0
timeout  output  1  poll ended after MAX_READS with busy still set; held until next start

Behaviour:
- Reset (async, any state): FSM=IDLE. lcd_e=0, lcd_rw=0, lcd_rs=0, active=0, done=0, ready=0, addr=0, timeout=0. Internal counters cleared.
- FSM states are IDLE, SETUP, EHIGH, EHOLD, GAP, DONE. All outputs are registered.
- IDLE -> SETUP when start=1:
  - latch wait_ready into mode
  - clear timeout
  - read_cnt=0
- SETUP: rw=1, rs=0, e=0, active=1 for SETUP_CYC cycles, then EHIGH.
- EHIGH: e=1 for exactly EHIGH_CYC cycles.
  - On the last cycle, register lcd_db_in: addr<=db[6:0], busy_s<=db[7].
  - read_cnt increments and saturates at 255.
- EHOLD: e=0, rw=1 for EHOLD_CYC cycles, then GAP.
- GAP: e=0, rw=1 for GAP_CYC cycles. At the end of GAP:
  - if mode=1, busy_s=1 and read_cnt<MAX_READS: go to SETUP (re-read)
  - else if mode=1, busy_s=1 and read_cnt==MAX_READS: timeout<=1, go to DONE
  - else: go to DONE
- DONE (one cycle):
  - done=1, ready<=~busy_s, active=0, rw=0
  - next state IDLE
- done is never high in any other state.
- Single-read latency: the cycle after start is sampled is SETUP cycle 1. done is high in cycle 1+SETUP_CYC+EHIGH_CYC+EHOLD_CYC+GAP_CYC, which is 42 with defaults.
- start is ignored in every non-IDLE state, including DONE. A start coincident with done is dropped.
- Changes to wait_ready mid-operation have no effect.
- lcd_db_in is sampled only on the last EHIGH cycle. Changes at any other time are ignored.
- ready, addr and timeout keep their values from the previous operation until updated. addr/ready update at the sample edge or DONE respectively, not at start.
- Counter widths: ceil(log2(max(param)))+1, minimum 5 bits. read_cnt is 8 bits.

Test Plan:
- Single read:
  - stimulus: rst pulse, start with wait_ready=0, lcd_db_in=0x85
  - response: one E pulse exactly 12 cycles wide, rw high for 41 cycles, done at cycle 42, addr=0x05, ready=0, timeout=0
- Polling:
  - stimulus: start with wait_ready=1; lcd_db_in=0x80 for the first 3 E pulses, then 0x10
  - response: exactly 4 E pulses, each separated by 25+2+2 low cycles; done once; ready=1, addr=0x10, timeout=0
- Timeout:
  - stimulus: MAX_READS=4, lcd_db_in held 0x80, wait_ready=1
  - response: exactly 4 E pulses, then done with timeout=1, ready=0, addr=0x00
- Reset mid-operation:
  - stimulus: assert rst during EHIGH cycle 5
  - response: lcd_e, lcd_rw and active go to 0 immediately (before the next clk edge); after release the block stays IDLE with no done pulse
- Ignored start:
  - stimulus: pulse start during SETUP, GAP and DONE
  - response: E pulse count and done timing are identical to the single-read case; no second operation starts
- Data sampling point:
  - stimulus: lcd_db_in=0xFF except on the last EHIGH cycle, where it is 0x2A
  - response: addr=0x2A, ready=1
